ime_cost_best: RTL and testbench
================================

Name: ime_cost_best

Overview:
- Parametrised successor to the per-partition SAD+MV-cost adder in the IME datapath.
- For every integer-search candidate, forms a saturated cost per partition (SAD + MV cost, or SAD only).
- Tracks the minimum cost and its MV for each partition across a whole search window.
- Sits between the SAD tree and the IME mode-decision logic; presents final best costs/MVs with a done pulse.

Parameters:
- PART_NUM, 5, number of partitions carried per candidate beat.
- SAD_LEN, 16, width of each SAD field.
- MVC_W, 12, width of mv_cost_i (unsigned, MVC_W <= SAD_LEN).
- COST_W, 16, width of each output cost field; costs saturate at 2^COST_W-1.
- MV_W, 10, width of each signed MV component.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; opens a new search window.
- mode_i  in  1  sampled with start_i; 0 = cost is SAD+mv_cost, 1 = cost is SAD only.
- sad_v_i  in  1  candidate beat valid.
- last_i  in  1  qualifies the final candidate; meaningful only with sad_v_i.
- mv_i  in  2*MV_W  candidate MV, {mvy, mvx}.
- mv_cost_i  in  MVC_W  MV cost of the candidate.
- sad_i  in  PART_NUM*SAD_LEN  partition SADs; partition p occupies bits [(p+1)*SAD_LEN-1 : p*SAD_LEN].
- busy_o  out  1  high from the cycle after start_i until done_o.
- done_o  out  1  one-cycle pulse; results final.
- best_cost_o  out  PART_NUM*COST_W  per-partition minimum cost, same packing as sad_i.
- best_mv_o  out  PART_NUM*2*MV_W  per-partition MV of the minimum.

Behaviour:
- States: IDLE, SEARCH, DRAIN, DONE.
  - IDLE -> SEARCH on start_i.
  - SEARCH -> DRAIN on sad_v_i & last_i.
  - DRAIN -> DONE after the pipeline empties (2 cycles).
  - DONE -> IDLE next cycle.
- Reset (synchronous, rst=1 at clock edge):
  - state=IDLE; busy_o=0; done_o=0.
  - best_cost_o all ones; best_mv_o=0.
  - Pipeline valids cleared.
- On start_i (any state):
  - Latch mode_i.
  - best_cost fields all ones; best_mv=0.
  - Pipeline valids cleared, so in-flight beats are discarded.
  - Enter SEARCH; busy_o=1 next cycle.
  - start_i in SEARCH or DRAIN aborts and restarts the search.
- Beat acceptance:
  - sad_v_i is accepted only in SEARCH, and only when start_i is low. start_i wins a same-cycle collision and the beat is dropped.
  - sad_v_i in IDLE, DRAIN or DONE is ignored.
- Stage 1 (register), per partition p:
  - sum = {0,sad_p} + (mode ? 0 : {0,mv_cost}), computed in SAD_LEN+1 bits.
  - cost_p = sum > 2^COST_W-1 ? all ones : sum[COST_W-1:0].
  - mv and last are registered alongside.
- Stage 2 (register), per partition p:
  - If cost_p < best_cost_p (strict), update best_cost_p and best_mv_p.
  - Ties keep the earlier candidate.
  - Partitions update independently.
- Latency:
  - Beat accepted at cycle t is reflected in best_* at t+2.
  - done_o asserts at t+2 after the last beat, aligned with the final update visible on outputs.
  - busy_o falls in the same cycle.
- best_* outputs:
  - Hold their values after done_o until the next start_i or rst.
  - Mid-search they show running minima; they are informative only, not guaranteed final.
- Missing last: if last_i never arrives, the block stays in SEARCH indefinitely. There is no timeout.
- Single-candidate window: start_i, then one beat with last_i, gives done_o 3 cycles after start_i's edge at the earliest.
- A cost equal to all ones never replaces the reset/initial best (strict compare). Best MV then stays 0.

Decomposition:
- Shared defines header (existing enc_defines): PART_NUM defaults per partition set, SAD_LEN/COST_W/MV_W/MVC_W values, FSM state encodings.
- One sub-module: ime_cost_sat_cmp, a single-partition adder+saturate plus compare/update register. It is instantiated PART_NUM times via generate.
- The FSM and valid pipeline stay in the top.

Test Plan:
- Basic min, mode 0, PART_NUM=5:
  - Stimulus: start; beats (sad_p=100, mvc=10, mv=(1,1)), (sad_p=90, mvc=30, mv=(2,2)), (sad_p=80, mvc=5, mv=(3,3), last).
  - Response: all best_cost=85, best_mv=(3,3); done_o exactly 2 cycles after the last beat; busy_o falls in the same cycle.
- Per-partition independence and tie:
  - Stimulus: beat A sad={50,60,70,80,90}; beat B sad={50,10,70,100,20}, mvc=0.
  - Response: costs {50,10,70,80,20}; MVs {A,B,A,A,B}. The tie on p0/p2 keeps A.
- Saturation:
  - Stimulus: sad_p=16'hFFF0, mvc=12'h0100, mode 0.
  - Response: cost=16'hFFFF; best stays at the initial MV 0. Same beat with mode 1 gives cost FFF0 and the MV updates.
- Abort:
  - Stimulus: start; two beats; start again in the cycle after the 2nd beat; then one beat sad=500 with last.
  - Response: best=500 (earlier beats discarded); exactly one done_o.
- Collisions and ignored beats:
  - Stimulus: sad_v_i in IDLE with sad=1; start_i coincident with sad_v_i (sad=2); then one beat sad=300 with last.
  - Response: best=300, i.e. both earlier beats dropped.
- Reset mid-search:
  - Stimulus: rst=1 for one cycle while in DRAIN.
  - Response: the next cycle shows done_o=0, busy_o=0, best_cost all ones, best_mv 0; no done_o follows.

Source files
------------

// File: rtl/ime_cost_best_pkg.sv
// ime_cost_best_pkg
// Shared definitions for the IME per-partition cost / best-candidate tracker:
// default geometry of the SAD beat and the control FSM state encoding.
package ime_cost_best_pkg;

    localparam int PART_NUM_DEF = 5;   // partitions carried per candidate beat
    localparam int SAD_LEN_DEF  = 16;  // width of one SAD field
    localparam int MVC_W_DEF    = 12;  // width of the MV cost (unsigned)
    localparam int COST_W_DEF   = 16;  // width of one saturated cost field
    localparam int MV_W_DEF     = 10;  // width of one signed MV component

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ime_cost_best_if.sv
// ime_cost_best_if
// Bundle between the SAD tree / search controller (master) and the cost
// tracker (slave).
//   start_i     : opens a new search window (pulse)
//   mode_i      : sampled with start_i, 1 = cost is SAD only
//   sad_v_i     : candidate beat valid
//   last_i      : final candidate of the window (with sad_v_i)
//   mv_i        : candidate MV {mvy, mvx}
//   mv_cost_i   : MV cost of the candidate
//   sad_i       : per-partition SADs, partition p at [(p+1)*SAD_LEN-1 : p*SAD_LEN]
//   busy_o      : search in progress
//   done_o      : one-cycle pulse, best_* are final
//   best_cost_o : per-partition minimum cost
//   best_mv_o   : per-partition MV of the minimum
interface ime_cost_best_if
    import ime_cost_best_pkg::*;
#(
    parameter int PART_NUM = PART_NUM_DEF,
    parameter int SAD_LEN  = SAD_LEN_DEF,
    parameter int MVC_W    = MVC_W_DEF,
    parameter int COST_W   = COST_W_DEF,
    parameter int MV_W     = MV_W_DEF
);

    logic                         start_i;
    logic                         mode_i;
    logic                         sad_v_i;
    logic                         last_i;
    logic [2*MV_W-1:0]            mv_i;
    logic [MVC_W-1:0]             mv_cost_i;
    logic [PART_NUM*SAD_LEN-1:0]  sad_i;
    logic                         busy_o;
    logic                         done_o;
    logic [PART_NUM*COST_W-1:0]   best_cost_o;
    logic [PART_NUM*2*MV_W-1:0]   best_mv_o;

    modport master (
        output start_i, mode_i, sad_v_i, last_i, mv_i, mv_cost_i, sad_i,
        input  busy_o, done_o, best_cost_o, best_mv_o
    );

    modport slave (
        input  start_i, mode_i, sad_v_i, last_i, mv_i, mv_cost_i, sad_i,
        output busy_o, done_o, best_cost_o, best_mv_o
    );

endinterface

// File: rtl/ime_cost_sat_cmp.sv
// ime_cost_sat_cmp
// One partition of the cost tracker: adds the MV cost to the SAD (unless in
// SAD-only mode), saturates to COST_W bits, registers the cost, then keeps the
// running minimum and its MV.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : start of a new window, restores the initial best
//   vld_p0     : beat accepted this cycle (stage-1 capture enable)
//   mode       : latched window mode, 1 = SAD only
//   sad        : SAD of this partition
//   mv_cost    : MV cost of the candidate
//   vld_p1     : stage-1 cost is valid
//   mv_p1      : MV registered alongside the stage-1 cost
//   best_cost  : running minimum cost
//   best_mv    : MV of the running minimum
module ime_cost_sat_cmp #(
    parameter int SAD_LEN = 16,
    parameter int MVC_W   = 12,
    parameter int COST_W  = 16,
    parameter int MV_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                vld_p0,
    input  logic                mode,
    input  logic [SAD_LEN-1:0]  sad,
    input  logic [MVC_W-1:0]    mv_cost,
    input  logic                vld_p1,
    input  logic [2*MV_W-1:0]   mv_p1,
    output logic [COST_W-1:0]   best_cost,
    output logic [2*MV_W-1:0]   best_mv
);

    localparam int SUM_W = SAD_LEN + 1;
    // Compare in a width that holds both the sum and the saturation limit.
    localparam int EXT_W = (SUM_W > COST_W) ? SUM_W : COST_W;

    function automatic logic [COST_W-1:0] sat_cost(input logic [SUM_W-1:0] sum);
        logic [EXT_W-1:0] ext;
        logic [EXT_W-1:0] lim;
        ext = EXT_W'(sum);
        lim = EXT_W'({COST_W{1'b1}});
        if (ext > lim) begin
            sat_cost = {COST_W{1'b1}};
        end else begin
            sat_cost = ext[COST_W-1:0];
        end
    endfunction

    logic [SUM_W-1:0]  add_p0;
    logic [SUM_W-1:0]  sum_p0;
    logic [COST_W-1:0] cost_p1;

    always_comb begin
        add_p0 = mode ? '0 : SUM_W'(mv_cost);
        sum_p0 = {1'b0, sad} + add_p0;
    end

    // ---- stage 1: saturated cost ----
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            cost_p1 <= sat_cost(sum_p0);
        end
    end

    // ---- stage 2: running minimum; strict compare keeps the earlier tie ----
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            best_cost <= '1;
            best_mv   <= '0;
        end else if (vld_p1 && (cost_p1 < best_cost)) begin
            best_cost <= cost_p1;
            best_mv   <= mv_p1;
        end
    end

endmodule

// File: rtl/ime_cost_best.sv
// ime_cost_best
// Per-partition SAD + MV-cost tracker for integer motion search. For every
// accepted candidate beat it forms a saturated cost per partition and keeps the
// minimum cost and its MV over the search window, then pulses done_o.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ime_cost_best_if slave (candidate beats in, best costs/MVs out)
module ime_cost_best
    import ime_cost_best_pkg::*;
#(
    parameter int PART_NUM = PART_NUM_DEF,
    parameter int SAD_LEN  = SAD_LEN_DEF,
    parameter int MVC_W    = MVC_W_DEF,
    parameter int COST_W   = COST_W_DEF,
    parameter int MV_W     = MV_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ime_cost_best_if.slave bus
);

    state_t state;
    state_t state_nxt;

    logic              accept_p0;
    logic              mode_q;
    logic              vld_p1;
    logic              last_p1;
    logic [2*MV_W-1:0] mv_p1;
    logic              busy;
    logic              done;

    logic [PART_NUM*COST_W-1:0] best_cost_all;
    logic [PART_NUM*2*MV_W-1:0] best_mv_all;

    // start_i wins a collision with a beat; beats outside SEARCH are dropped.
    assign accept_p0 = (state == ST_SEARCH) && bus.sad_v_i && !bus.start_i;

    // ---- stage 1: control alongside the per-partition cost registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.start_i) begin
                mode_q <= bus.mode_i;
            end
            // accept_p0 is low whenever start_i is high, so a restart also
            // flushes any beat that was about to enter the pipeline.
            vld_p1  <= accept_p0;
            last_p1 <= accept_p0 && bus.last_i;
        end
    end

    always_ff @(posedge clk) begin
        mv_p1 <= bus.mv_i;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_SEARCH: begin
                busy = 1'b1;
                if (accept_p0 && bus.last_i) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // The last beat sits in stage 1 now and lands in best_* on this
                // edge, so DONE shows final results.
                if (vld_p1 && last_p1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (bus.start_i) begin
            state_nxt = ST_SEARCH;
        end
    end

    // ---- stage 2: per-partition compare/update ----
    for (genvar p = 0; p < PART_NUM; p++) begin : g_part
        ime_cost_sat_cmp #(
            .SAD_LEN (SAD_LEN),
            .MVC_W   (MVC_W),
            .COST_W  (COST_W),
            .MV_W    (MV_W)
        ) u_sat_cmp (
            .clk       (clk),
            .rst       (rst),
            .clr       (bus.start_i),
            .vld_p0    (accept_p0),
            .mode      (mode_q),
            .sad       (bus.sad_i[p*SAD_LEN +: SAD_LEN]),
            .mv_cost   (bus.mv_cost_i),
            .vld_p1    (vld_p1),
            .mv_p1     (mv_p1),
            .best_cost (best_cost_all[p*COST_W +: COST_W]),
            .best_mv   (best_mv_all[p*2*MV_W +: 2*MV_W])
        );
    end

    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.best_cost_o = best_cost_all;
    assign bus.best_mv_o   = best_mv_all;

endmodule

// File: tb/tb_ime_cost_best.sv
// tb_ime_cost_best
// Randomized and directed stimulus for ime_cost_best, checked each cycle
// against a window-level reference model (list of accepted candidates, minimum
// taken in arrival order).
module tb_ime_cost_best;

    localparam int PN = 5;
    localparam int SL = 16;
    localparam int MW = 12;
    localparam int CW = 16;
    localparam int VW = 10;

    typedef logic [PN-1:0][SL-1:0]   sad_t;
    typedef logic [PN-1:0][CW-1:0]   cost_t;
    typedef logic [PN-1:0][2*VW-1:0] mvs_t;

    typedef struct packed {
        cost_t             cost;
        logic [2*VW-1:0]   mv;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ime_cost_best_if #(
        .PART_NUM(PN), .SAD_LEN(SL), .MVC_W(MW), .COST_W(CW), .MV_W(VW)
    ) bus ();

    ime_cost_best #(
        .PART_NUM(PN), .SAD_LEN(SL), .MVC_W(MW), .COST_W(CW), .MV_W(VW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model state
    beat_t win_q[$];
    bit    m_search = 1'b0;
    bit    m_mode   = 1'b0;
    int    m_dd     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] ref_cost(input int sad, input int mvc, input bit md);
        int s;
        s = sad + (md ? 0 : mvc);
        if (s > (1 << CW) - 1) return {CW{1'b1}};
        return s[CW-1:0];
    endfunction

    function automatic logic [2*VW-1:0] mvp(input int y, input int x);
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        a = y[VW-1:0];
        b = x[VW-1:0];
        return {a, b};
    endfunction

    function automatic sad_t rep(input int v);
        sad_t s;
        for (int p = 0; p < PN; p++) s[p] = v[SL-1:0];
        return s;
    endfunction

    task automatic ref_best(output cost_t bc, output mvs_t bm);
        for (int p = 0; p < PN; p++) begin
            bc[p] = {CW{1'b1}};
            bm[p] = '0;
            foreach (win_q[i]) begin
                if (win_q[i].cost[p] < bc[p]) begin
                    bc[p] = win_q[i].cost[p];
                    bm[p] = win_q[i].mv;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input bit r, input bit st, input bit md, input bit v, input bit lst,
                        input logic [2*VW-1:0] mv, input logic [MW-1:0] mvc, input sad_t sad);
        cost_t bc;
        mvs_t  bm;
        cost_t gc;
        mvs_t  gm;
        beat_t b;
        rst           = r;
        bus.start_i   = st;
        bus.mode_i    = md;
        bus.sad_v_i   = v;
        bus.last_i    = lst;
        bus.mv_i      = mv;
        bus.mv_cost_i = mvc;
        bus.sad_i     = sad;
        @(posedge clk);
        if (r) begin
            m_search = 1'b0;
            m_dd     = 0;
            win_q.delete();
        end else if (st) begin
            m_search = 1'b1;
            m_mode   = md;
            m_dd     = 0;
            win_q.delete();
        end else begin
            if (m_dd > 0) m_dd--;
            if (m_search && v) begin
                for (int p = 0; p < PN; p++) b.cost[p] = ref_cost(int'(sad[p]), int'(mvc), m_mode);
                b.mv = mv;
                win_q.push_back(b);
                if (lst) begin
                    m_search = 1'b0;
                    m_dd     = 2;
                end
            end
        end
        #1;
        chk("done", 32'(bus.done_o), 32'(m_dd == 1));
        chk("busy", 32'(bus.busy_o), 32'(m_search || m_dd == 2));
        if (!m_search && m_dd != 2) begin
            ref_best(bc, bm);
            gc = bus.best_cost_o;
            gm = bus.best_mv_o;
            for (int p = 0; p < PN; p++) begin
                chk($sformatf("best_cost[%0d]", p), 32'(gc[p]), 32'(bc[p]));
                chk($sformatf("best_mv[%0d]", p), 32'(gm[p]), 32'(bm[p]));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, '0, '0);
    endtask

    function automatic cost_t get_cost();
        cost_t c;
        c = bus.best_cost_o;
        return c;
    endfunction

    function automatic mvs_t get_mv();
        mvs_t m;
        m = bus.best_mv_o;
        return m;
    endfunction

    initial begin
        sad_t  sa;
        sad_t  sb;
        cost_t c;
        mvs_t  m;

        // reset
        step(1, 0, 0, 0, 0, '0, '0, '0);
        step(1, 0, 0, 0, 0, '0, '0, '0);
        c = get_cost();
        chk("rst_cost", 32'(c[0]), 32'hFFFF);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        idle(2);

        // basic minimum, mode 0
        step(0, 1, 0, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 0, mvp(1, 1), 12'd10, rep(100));
        step(0, 0, 0, 1, 0, mvp(2, 2), 12'd30, rep(90));
        step(0, 0, 0, 1, 1, mvp(3, 3), 12'd5,  rep(80));
        chk("basic_busy_drain", 32'(bus.busy_o), 32'd1);
        idle(1);
        c = get_cost();
        m = get_mv();
        chk("basic_done", 32'(bus.done_o), 32'd1);
        chk("basic_busy_fall", 32'(bus.busy_o), 32'd0);
        for (int p = 0; p < PN; p++) begin
            chk("basic_cost", 32'(c[p]), 32'd85);
            chk("basic_mv", 32'(m[p]), 32'(mvp(3, 3)));
        end
        idle(2);

        // per-partition independence and ties
        sa[0] = 50; sa[1] = 60; sa[2] = 70; sa[3] = 80;  sa[4] = 90;
        sb[0] = 50; sb[1] = 10; sb[2] = 70; sb[3] = 100; sb[4] = 20;
        step(0, 1, 0, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 0, mvp(-1, 5), 12'd0, sa);
        step(0, 0, 0, 1, 1, mvp(7, -3), 12'd0, sb);
        idle(1);
        c = get_cost();
        m = get_mv();
        chk("tie_cost1", 32'(c[1]), 32'd10);
        chk("tie_cost3", 32'(c[3]), 32'd80);
        chk("tie_mv0", 32'(m[0]), 32'(mvp(-1, 5)));
        chk("tie_mv4", 32'(m[4]), 32'(mvp(7, -3)));
        idle(1);

        // saturation, mode 0 then mode 1
        step(0, 1, 0, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 1, mvp(4, 4), 12'h100, rep(16'hFFF0));
        idle(1);
        c = get_cost();
        m = get_mv();
        chk("sat_cost", 32'(c[2]), 32'hFFFF);
        chk("sat_mv", 32'(m[2]), 32'd0);
        step(0, 1, 1, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 1, mvp(4, 4), 12'h100, rep(16'hFFF0));
        idle(1);
        c = get_cost();
        m = get_mv();
        chk("sad_only_cost", 32'(c[2]), 32'hFFF0);
        chk("sad_only_mv", 32'(m[2]), 32'(mvp(4, 4)));
        idle(1);

        // abort and restart
        step(0, 1, 0, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 0, mvp(1, 2), 12'd0, rep(5));
        step(0, 0, 0, 1, 0, mvp(2, 1), 12'd0, rep(6));
        step(0, 1, 0, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 1, mvp(9, 9), 12'd0, rep(500));
        idle(1);
        c = get_cost();
        chk("abort_cost", 32'(c[4]), 32'd500);
        idle(3);

        // ignored beat in IDLE and start/beat collision
        step(0, 0, 0, 1, 0, mvp(1, 1), 12'd0, rep(1));
        step(0, 1, 0, 1, 0, mvp(2, 2), 12'd0, rep(2));
        step(0, 0, 0, 1, 1, mvp(3, 3), 12'd0, rep(300));
        idle(1);
        c = get_cost();
        chk("collide_cost", 32'(c[0]), 32'd300);
        idle(1);

        // reset while draining
        step(0, 1, 0, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 1, mvp(6, 6), 12'd3, rep(40));
        step(1, 0, 0, 0, 0, '0, '0, '0);
        c = get_cost();
        chk("rst_drain_cost", 32'(c[1]), 32'hFFFF);
        chk("rst_drain_done", 32'(bus.done_o), 32'd0);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            sad_t s;
            bit   r;
            bit   st;
            bit   v;
            bit   l;
            logic [MW-1:0] mc;
            for (int p = 0; p < PN; p++) begin
                case ($urandom_range(0, 2))
                    0:       s[p] = SL'($urandom_range(0, 15));
                    1:       s[p] = SL'($urandom);
                    default: s[p] = SL'($urandom_range(16'hFF00, 16'hFFFF));
                endcase
            end
            r  = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 11) == 0);
            v  = ($urandom_range(0, 2) != 0);
            l  = ($urandom_range(0, 5) == 0);
            mc = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom);
            step(r, st, 1'($urandom), v, l, 20'($urandom), mc, s);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
